// File: rtl/dist_sync_fifo_if.sv
// Bus bundle for dist_sync_fifo: write side, read side and status flags.
// Optional sticky error outputs exist only when DFIFO_ERR_FLAG_EN is defined.
interface dist_sync_fifo_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
`ifdef DFIFO_ERR_FLAG_EN
    logic                  overflow;
    logic                  underflow;
`endif

    modport master (
`ifdef DFIFO_ERR_FLAG_EN
        input  overflow, underflow,
`endif
        output wr_en, wr_data, rd_en,
        input  full, almost_full, rd_data, rd_valid, empty, almost_empty, count
    );

    modport slave (
`ifdef DFIFO_ERR_FLAG_EN
        output overflow, underflow,
`endif
        input  wr_en, wr_data, rd_en,
        output full, almost_full, rd_data, rd_valid, empty, almost_empty, count
    );
endinterface

// File: rtl/dist_sync_fifo.sv
// Single-clock FIFO on distributed RAM with registered flags, count, flush and FWFT mode.
// Define DFIFO_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module dist_sync_fifo #(
    parameter int ADDR_WIDTH      = 5,
    parameter int DATA_WIDTH      = 32,
    parameter int FWFT            = 0,
    parameter int ALMOST_FULL_TH  = 28,
    parameter int ALMOST_EMPTY_TH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    dist_sync_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);
    localparam logic [CW-1:0] AF_V    = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_V    = CW'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  empty_q, empty_d;
    logic                  full_q;
    logic                  almost_full_q;
    logic                  almost_empty_q;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  load;
    logic                  ram_empty;
    logic [DATA_WIDTH-1:0] head_word;

    // Asynchronous read of the word at the read pointer.
    assign head_word = mem[rd_ptr_q[ADDR_WIDTH-1:0]];

    // Flush wins over a same-cycle write, so the RAM is left untouched.
    assign wr_acc = bus.wr_en & ~full_q & ~clr;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    always_comb begin
        rd_acc     = bus.rd_en & ~empty_q;
        ram_empty  = (wr_ptr_q == rd_ptr_q);
        load       = 1'b0;
        wr_ptr_d   = wr_ptr_q + CW'(wr_acc);
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        empty_d    = 1'b1;

        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end

        if (FWFT != 0) begin
            // Refill the holding register when it is vacant or being consumed.
            load       = (~rd_valid_q | rd_acc) & ~ram_empty;
            rd_valid_d = load | (rd_valid_q & ~rd_acc);
            empty_d    = ~rd_valid_d;
        end else begin
            load       = rd_acc;
            rd_valid_d = rd_acc;
            empty_d    = (count_d == '0);
        end

        rd_ptr_d = rd_ptr_q + CW'(load);
        if (load) begin
            rd_data_d = head_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else if (clr) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            empty_q        <= empty_d;
            full_q         <= (count_d == DEPTH_V);
            almost_full_q  <= (count_d >= AF_V);
            almost_empty_q <= (count_d <= AE_V);
        end
    end

    assign bus.full         = full_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.count        = count_q;

`ifdef DFIFO_ERR_FLAG_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky: once a rejected access is seen it stays flagged until flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (bus.wr_en & full_q);
            underflow_q <= underflow_q | (bus.rd_en & empty_q);
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_dist_sync_fifo.sv
// Scoreboard bench for dist_sync_fifo: one standard-mode and one FWFT instance,
// directed stimulus queues expected read words, negedge monitors pop and compare.
module tb_dist_sync_fifo;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [DW-1:0] exp_std[$];
    logic [DW-1:0] exp_fwft[$];

    dist_sync_fifo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sif ();
    dist_sync_fifo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fif ();

    dist_sync_fifo #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0),
        .ALMOST_FULL_TH(28), .ALMOST_EMPTY_TH(4)
    ) dut_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(sif)
    );

    dist_sync_fifo #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1),
        .ALMOST_FULL_TH(28), .ALMOST_EMPTY_TH(4)
    ) dut_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(fif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Standard mode: every rd_valid pulse is one delivered word.
    always @(negedge clk) begin
        if (rst_n && sif.rd_valid) begin
            if (exp_std.size() == 0) begin
                total_cnt++;
                $display("FAIL std_rd_data: got unexpected word %0h expected none", sif.rd_data);
            end else begin
                check("std_rd_data", 64'(sif.rd_data), 64'(exp_std.pop_front()));
            end
        end
    end

    // FWFT mode: a word is delivered when presented and consumed.
    always @(negedge clk) begin
        if (rst_n && fif.rd_valid && fif.rd_en) begin
            if (exp_fwft.size() == 0) begin
                total_cnt++;
                $display("FAIL fwft_rd_data: got unexpected word %0h expected none", fif.rd_data);
            end else begin
                check("fwft_rd_data", 64'(fif.rd_data), 64'(exp_fwft.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        sif.wr_en = 1'b0; sif.wr_data = '0; sif.rd_en = 1'b0;
        fif.wr_en = 1'b0; fif.wr_data = '0; fif.rd_en = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_count",        64'(sif.count), 64'd0);
        check("rst_empty",        64'(sif.empty), 64'd1);
        check("rst_almost_empty", 64'(sif.almost_empty), 64'd1);
        check("rst_full",         64'(sif.full), 64'd0);
        check("rst_almost_full",  64'(sif.almost_full), 64'd0);
        check("rst_rd_valid",     64'(sif.rd_valid), 64'd0);
        check("rst_rd_data",      64'(sif.rd_data), 64'd0);
        check("rst_fwft_empty",   64'(fif.empty), 64'd1);
        check("rst_fwft_valid",   64'(fif.rd_valid), 64'd0);
        rst_n = 1'b1;
        tick();

        // Fill standard FIFO with 0..31
        for (int i = 0; i < DEPTH; i++) begin
            sif.wr_en = 1'b1; sif.wr_data = DW'(i);
            tick();
            check("fill_count", 64'(sif.count), 64'(i + 1));
            check("fill_almost_full", 64'(sif.almost_full), 64'((i + 1) >= 28));
            check("fill_full", 64'(sif.full), 64'(i == DEPTH - 1));
        end
        // Write while full is dropped
        sif.wr_data = 32'hDEAD_BEEF;
        tick();
        sif.wr_en = 1'b0;
        check("ovf_count", 64'(sif.count), 64'd32);
        check("ovf_full", 64'(sif.full), 64'd1);
`ifdef DFIFO_ERR_FLAG_EN
        check("ovf_flag", 64'(sif.overflow), 64'd1);
`endif

        // Drain 0..31
        for (int i = 0; i < DEPTH; i++) begin
            sif.rd_en = 1'b1;
            exp_std.push_back(DW'(i));
            tick();
            check("drain_count", 64'(sif.count), 64'(31 - i));
            check("drain_almost_empty", 64'(sif.almost_empty), 64'((31 - i) <= 4));
        end
        sif.rd_en = 1'b0;
        check("drain_empty", 64'(sif.empty), 64'd1);
        tick();
        // Read while empty is ignored
        sif.rd_en = 1'b1;
        tick();
        sif.rd_en = 1'b0;
        check("udf_rd_valid", 64'(sif.rd_valid), 64'd0);
        check("udf_rd_data_hold", 64'(sif.rd_data), 64'd31);
        check("udf_count", 64'(sif.count), 64'd0);
`ifdef DFIFO_ERR_FLAG_EN
        check("udf_flag", 64'(sif.underflow), 64'd1);
        check("ovf_flag_sticky", 64'(sif.overflow), 64'd1);
`endif

        // Continuous read+write at count 16, pointers wrap
        for (int i = 0; i < 16; i++) begin
            sif.wr_en = 1'b1; sif.wr_data = DW'(100 + i);
            tick();
        end
        check("stream_prefill", 64'(sif.count), 64'd16);
        for (int k = 0; k < 100; k++) begin
            sif.wr_en = 1'b1; sif.wr_data = DW'(116 + k);
            sif.rd_en = 1'b1;
            exp_std.push_back(DW'(100 + k));
            tick();
            check("stream_count", 64'(sif.count), 64'd16);
        end
        sif.wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sif.rd_en = 1'b1;
            exp_std.push_back(DW'(200 + i));
            tick();
            check("stream_drain_count", 64'(sif.count), 64'(15 - i));
        end
        sif.rd_en = 1'b0;
        tick();
        check("std_scoreboard_drained", 64'(exp_std.size()), 64'd0);

        // Asynchronous reset mid-burst at count 10
        for (int i = 0; i < 10; i++) begin
            sif.wr_en = 1'b1; sif.wr_data = DW'(300 + i);
            tick();
        end
        sif.wr_data = DW'(310); sif.rd_en = 1'b1;
        exp_std.push_back(DW'(300));
        tick();
        check("burst_count", 64'(sif.count), 64'd10);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_count", 64'(sif.count), 64'd0);
        check("arst_empty", 64'(sif.empty), 64'd1);
        check("arst_rd_valid", 64'(sif.rd_valid), 64'd0);
        check("arst_almost_empty", 64'(sif.almost_empty), 64'd1);
        check("arst_rd_data", 64'(sif.rd_data), 64'd0);
`ifdef DFIFO_ERR_FLAG_EN
        check("arst_overflow", 64'(sif.overflow), 64'd0);
        check("arst_underflow", 64'(sif.underflow), 64'd0);
`endif
        sif.wr_en = 1'b0; sif.rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        check("arst_hold_empty", 64'(sif.empty), 64'd1);
        tick();
        // Read while empty after reset, then flush during a write
        sif.rd_en = 1'b1;
        tick();
        sif.rd_en = 1'b0;
`ifdef DFIFO_ERR_FLAG_EN
        check("udf_flag_again", 64'(sif.underflow), 64'd1);
`endif
        clr = 1'b1; sif.wr_en = 1'b1; sif.wr_data = 32'h0000_0400;
        tick();
        clr = 1'b0; sif.wr_en = 1'b0;
        check("clr_count", 64'(sif.count), 64'd0);
        check("clr_empty", 64'(sif.empty), 64'd1);
`ifdef DFIFO_ERR_FLAG_EN
        check("clr_underflow", 64'(sif.underflow), 64'd0);
`endif
        tick();
        check("clr_count_after", 64'(sif.count), 64'd0);
        check("clr_rd_valid", 64'(sif.rd_valid), 64'd0);

        // FWFT: single word, latency 2
        fif.wr_en = 1'b1; fif.wr_data = 32'hA5A5_A5A5;
        tick();
        fif.wr_en = 1'b0;
        check("fwft_n_valid", 64'(fif.rd_valid), 64'd0);
        check("fwft_n_empty", 64'(fif.empty), 64'd1);
        check("fwft_n_count", 64'(fif.count), 64'd1);
        tick();
        check("fwft_n1_valid", 64'(fif.rd_valid), 64'd1);
        check("fwft_n1_data", 64'(fif.rd_data), 64'hA5A5_A5A5);
        check("fwft_n1_empty", 64'(fif.empty), 64'd0);
        exp_fwft.push_back(32'hA5A5_A5A5);
        fif.rd_en = 1'b1;
        tick();
        fif.rd_en = 1'b0;
        check("fwft_pop_empty", 64'(fif.empty), 64'd1);
        check("fwft_pop_count", 64'(fif.count), 64'd0);

        // FWFT: three words, back-to-back consumption
        for (int i = 0; i < 3; i++) begin
            fif.wr_en = 1'b1; fif.wr_data = DW'(16 + i);
            tick();
        end
        fif.wr_en = 1'b0;
        check("fwft3_count", 64'(fif.count), 64'd3);
        check("fwft3_head", 64'(fif.rd_data), 64'h10);
        for (int i = 0; i < 3; i++) begin
            fif.rd_en = 1'b1;
            exp_fwft.push_back(DW'(16 + i));
            tick();
            check("fwft3_count_rd", 64'(fif.count), 64'(2 - i));
        end
        fif.rd_en = 1'b0;
        check("fwft3_empty", 64'(fif.empty), 64'd1);

        // FWFT: capacity is DEPTH including the holding register
        for (int i = 0; i < DEPTH; i++) begin
            fif.wr_en = 1'b1; fif.wr_data = DW'(500 + i);
            tick();
        end
        check("fwft_full_count", 64'(fif.count), 64'd32);
        check("fwft_full", 64'(fif.full), 64'd1);
        check("fwft_almost_full", 64'(fif.almost_full), 64'd1);
        fif.wr_data = 32'h0000_0BAD;
        tick();
        fif.wr_en = 1'b0;
        check("fwft_ovf_count", 64'(fif.count), 64'd32);
`ifdef DFIFO_ERR_FLAG_EN
        check("fwft_ovf_flag", 64'(fif.overflow), 64'd1);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            fif.rd_en = 1'b1;
            exp_fwft.push_back(DW'(500 + i));
            tick();
            check("fwft_drain_count", 64'(fif.count), 64'(31 - i));
        end
        fif.rd_en = 1'b0;
        check("fwft_drain_empty", 64'(fif.empty), 64'd1);
        check("fwft_drain_almost_empty", 64'(fif.almost_empty), 64'd1);
        tick();
        check("fwft_scoreboard_drained", 64'(exp_fwft.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
